// File: rtl/user_module.sv
// Two-input gate demonstrator tile: combinational gate bank on A/B, a registered
// AND copy, a heartbeat, and a counter of AND rising edges for on-silicon observation.
module user_module #(
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic             w_a;
  logic             w_b;
  logic             w_and;
  logic             w_rise;
  logic             w_unused;
  logic             r_and_q;
  logic             r_hb_q;
  logic [CNT_W-1:0] r_evt_q;

  assign w_a      = ui_in[0];
  assign w_b      = ui_in[1];
  assign w_and    = w_a & w_b;
  assign w_unused = ^{uio_in, ui_in[7:2]};

  // Edge detect uses the pre-edge and_q, so a held-high AND counts once.
  assign w_rise = w_and & ~r_and_q;

  // rst_n is active-high here; reset wins over ena.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_and_q <= 1'b0;
      r_hb_q  <= 1'b0;
      r_evt_q <= '0;
    end else if (ena) begin
      r_and_q <= w_and;
      r_hb_q  <= ~r_hb_q;
      if (w_rise) r_evt_q <= r_evt_q + 1'b1;
    end
  end

  always_comb begin
    uo_out    = '0;
    uo_out[0] = w_and;
    uo_out[1] = w_a | w_b;
    uo_out[2] = w_a ^ w_b;
    uo_out[3] = ~(w_a & w_b);
    uo_out[4] = ~(w_a | w_b);
    uo_out[5] = ~(w_a ^ w_b);
    uo_out[6] = r_and_q;
    uo_out[7] = r_hb_q;
  end

  assign uio_out = r_evt_q;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_user_module.sv
// Directed bench for the gate demonstrator tile: gate truth table, reset,
// AND edge counting, enable freeze and counter wrap.
module tb_user_module;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_chk;
  int n_err;
  logic exp_hb;

  user_module dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; heartbeat expectation follows reset/enable at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) exp_hb = 1'b0;
    else if (ena) exp_hb = ~exp_hb;
    #1;
    chk("hb", uo_out[7], exp_hb);
  endtask

  task automatic set_ab(input logic a, input logic b);
    ui_in = {6'b101010, b, a};
    #1;
  endtask

  task automatic pulse();
    set_ab(1, 1); tick();
    set_ab(0, 0); tick();
  endtask

  logic [1:0] ab_tab [4];
  logic [5:0] gate_tab [4];

  initial begin
    n_chk = 0; n_err = 0; exp_hb = 1'b0;
    rst_n = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'hA5;
    ab_tab[0] = 2'b00; gate_tab[0] = 6'b111000;
    ab_tab[1] = 2'b01; gate_tab[1] = 6'b001110;
    ab_tab[2] = 2'b10; gate_tab[2] = 6'b001110;
    ab_tab[3] = 2'b11; gate_tab[3] = 6'b100011;

    // Initial reset
    #2; tick(); tick();
    chk("rst_evt", uio_out, 8'h00);
    chk("rst_q", uo_out[7:6], 2'b00);
    chk("oe", uio_oe, 8'hFF);

    // Gate truth table out of reset, each combination held two clocks
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ab(ab_tab[i][0], ab_tab[i][1]);
      chk("gates", uo_out[5:0], gate_tab[i]);
      tick(); tick();
      chk("gates_held", uo_out[5:0], gate_tab[i]);
    end
    chk("evt_after_tt", uio_out, 8'h01);

    // Count to 5 then reset mid-count with A&B=1
    set_ab(0, 0); tick();
    for (int i = 0; i < 4; i++) pulse();
    chk("evt5", uio_out, 8'h05);
    set_ab(1, 1); rst_n = 1'b1;
    chk("gates_in_rst", uo_out[5:0], 6'b100011);
    tick();
    chk("rst_mid_evt", uio_out, 8'h00);
    chk("rst_mid_q", uo_out[7:6], 2'b00);
    chk("and_in_rst", uo_out[0], 1'b1);
    rst_n = 1'b0;
    set_ab(0, 0); tick();
    chk("post_rst_evt", uio_out, 8'h00);

    // Three 00->11 toggles, two clocks per phase
    for (int i = 0; i < 3; i++) begin
      set_ab(1, 1);
      chk("andq_lag0", uo_out[6], 1'b0);
      tick();
      chk("andq_lag1", uo_out[6], 1'b1);
      tick();
      set_ab(0, 0);
      chk("andq_fall0", uo_out[6], 1'b1);
      tick();
      chk("andq_fall1", uo_out[6], 1'b0);
      tick();
    end
    chk("evt3", uio_out, 8'h03);

    // Held AND counts exactly once
    set_ab(1, 1);
    for (int i = 0; i < 10; i++) tick();
    chk("evt_hold", uio_out, 8'h04);
    set_ab(0, 0); tick();

    // Enable low freezes registered state
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ab(1, 1);
      chk("dis_and1", uo_out[0], 1'b1);
      tick();
      chk("dis_evt", uio_out, 8'h04);
      chk("dis_andq", uo_out[6], 1'b0);
      set_ab(0, 0);
      chk("dis_and0", uo_out[0], 1'b0);
      tick();
    end
    ena = 1'b1;

    // Wrap: 255 edges then one more
    rst_n = 1'b1; tick(); rst_n = 1'b0;
    for (int i = 0; i < 255; i++) begin
      pulse();
      if (uio_oe !== 8'hFF) chk("oe_loop", uio_oe, 8'hFF);
    end
    chk("evt_ff", uio_out, 8'hFF);
    pulse();
    chk("evt_wrap", uio_out, 8'h00);
    chk("oe_end", uio_oe, 8'hFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
